// File: rtl/csa_accum_ctrl_if.sv
// Handshake bundle for csa_accum_ctrl: operand beats in, one result per job out.
interface csa_accum_ctrl_if #(
  parameter int W     = 8,
  parameter int ACC_W = 16,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_a;
  logic [W-1:0]     in_b;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_count;
  logic             out_cnt_sat;

  // producer/consumer side
  modport master (
    output in_valid, in_a, in_b, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_cnt_sat
  );

  // accumulator side
  modport slave (
    input  in_valid, in_a, in_b, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_cnt_sat
  );
endinterface

// File: rtl/csa_accum_ctrl.sv
// Carry-save multi-operand accumulator: one 4:2 compressor row folds two
// operands per beat into (s, c); a single CPA add resolves the job total.

// One 4:2 compressor bit cell. cout does not depend on cin, so the row has
// no horizontal ripple.
module csa_cell (
  input  logic a,
  input  logic b,
  input  logic s,
  input  logic c,
  input  logic cin,
  output logic sum,
  output logic cout,
  output logic carry
);
  logic x;
  assign x     = a ^ b ^ s;
  assign sum   = x ^ c ^ cin;
  assign cout  = (a & b) | (a & s) | (b & s);
  assign carry = (x & c) | (x & cin) | (c & cin);
endmodule

module csa_accum_ctrl #(
  parameter int W     = 8,
  parameter int ACC_W = 16,
  parameter int CNT_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  csa_accum_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state;
  logic [ACC_W-1:0] s_q, c_q, result_q;
  logic [CNT_W-1:0] cnt_q;
  logic             sat_q, in_ready_q, out_valid_q;

  logic [ACC_W-1:0] op_a, op_b, nxt_s, nxt_c;
  logic [ACC_W-1:0] row_cout, row_carry;
  logic             accept;

  assign op_a   = {{(ACC_W-W){1'b0}}, bus.in_a};
  assign op_b   = {{(ACC_W-W){1'b0}}, bus.in_b};
  assign accept = bus.in_valid && in_ready_q;

  // Compressor row; the MSB's cout and carry would land above ACC_W, so
  // that bit only computes its sum.
  genvar i;
  generate
    for (i = 0; i < ACC_W; i++) begin : g_row
      logic cin;
      if (i == 0) begin : g_cin0
        assign cin = 1'b0;
      end else begin : g_cinn
        assign cin = row_cout[i-1];
      end
      if (i < ACC_W-1) begin : g_cell
        csa_cell u_cell (
          .a(op_a[i]), .b(op_b[i]), .s(s_q[i]), .c(c_q[i]), .cin(cin),
          .sum(nxt_s[i]), .cout(row_cout[i]), .carry(row_carry[i])
        );
      end else begin : g_msb
        assign nxt_s[i]     = op_a[i] ^ op_b[i] ^ s_q[i] ^ c_q[i] ^ cin;
        assign row_cout[i]  = 1'b0;
        assign row_carry[i] = 1'b0;
      end
    end
  endgenerate

  assign nxt_c = {row_carry[ACC_W-2:0], 1'b0};

  // Controller: sequences accumulate / resolve / present, all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      s_q         <= '0;
      c_q         <= '0;
      result_q    <= '0;
      cnt_q       <= '0;
      sat_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (clr) begin
      state       <= IDLE;
      s_q         <= '0;
      c_q         <= '0;
      result_q    <= '0;
      cnt_q       <= '0;
      sat_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            s_q <= nxt_s;
            c_q <= nxt_c;
            if (cnt_q == CNT_MAX) sat_q <= 1'b1;
            else                  cnt_q <= cnt_q + 1'b1;
            if (bus.in_last) begin
              state      <= RESOLVE;
              in_ready_q <= 1'b0;
            end else begin
              state <= ACCUM;
            end
          end
        end
        RESOLVE: begin
          result_q    <= s_q + c_q;
          out_valid_q <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            s_q         <= '0;
            c_q         <= '0;
            cnt_q       <= '0;
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_sum     = result_q;
  assign bus.out_count   = cnt_q;
  assign bus.out_cnt_sat = sat_q;
endmodule

// File: tb/tb_csa_accum_ctrl.sv
// Self-checking bench for csa_accum_ctrl: table of jobs, corner sequences,
// and random jobs against a plain-arithmetic reference.
module tb_csa_accum_ctrl;
  logic clk, rst_n, clr;
  int   n_chk = 0, n_err = 0;
  int unsigned qa[$], qb[$];

  csa_accum_ctrl_if #(.W(8), .ACC_W(16), .CNT_W(8)) bus ();

  csa_accum_ctrl #(.W(8), .ACC_W(16), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  typedef struct {
    int unsigned a, b;
    int          n;
    int          hold;
    int unsigned exp_sum, exp_cnt, exp_sat;
  } job_t;

  task automatic chk(input string name, input int unsigned got, input int unsigned exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  // Drive queued beats; returns the number of cycles a valid beat stalled.
  task automatic send_beats(input bit gaps, input bit last_en, output int stalls);
    int k = 0, guard = 0;
    stalls = 0;
    while (k < qa.size() && guard < 20000) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        bus.in_valid = 1'b0;
      end else begin
        bus.in_valid = 1'b1;
        bus.in_a     = 8'(qa[k]);
        bus.in_b     = 8'(qb[k]);
        bus.in_last  = last_en && (k == qa.size() - 1);
      end
      #1;
      if (bus.in_valid && bus.in_ready) k++;
      else if (bus.in_valid) stalls++;
      @(negedge clk);
      guard++;
    end
    if (k < qa.size()) chk("send_timeout", k, qa.size());
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // Full job: send, check latency/ready gap, hold under back-pressure, retire.
  task automatic run_job(input string nm, input bit gaps, input int hold,
                         input int unsigned es, input int unsigned ec, input int unsigned esat);
    int stalls, lat;
    int unsigned s0;
    send_beats(gaps, 1'b1, stalls);
    if (!gaps) chk({nm, "_bubbles"}, stalls, 0);
    chk({nm, "_ready_resolve"}, bus.in_ready, 0);
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, "_latency"}, lat, 2);
    chk({nm, "_sum"}, bus.out_sum, es);
    chk({nm, "_count"}, bus.out_count, ec);
    chk({nm, "_sat"}, bus.out_cnt_sat, esat);
    chk({nm, "_ready_done"}, bus.in_ready, 0);
    s0 = bus.out_sum;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({nm, "_hold_valid"}, bus.out_valid, 1);
      chk({nm, "_hold_sum"}, bus.out_sum, s0);
      chk({nm, "_hold_ready"}, bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({nm, "_retire_valid"}, bus.out_valid, 0);
    chk({nm, "_retire_ready"}, bus.in_ready, 1);
  endtask

  task automatic fill(input int unsigned a, input int unsigned b, input int n);
    qa.delete(); qb.delete();
    for (int i = 0; i < n; i++) begin qa.push_back(a); qb.push_back(b); end
  endtask

  initial begin
    job_t tbl[5];
    int st, n;
    int unsigned ref_sum;

    tbl[0] = '{a:3,   b:5,   n:1,   hold:0, exp_sum:16'h0008, exp_cnt:1,   exp_sat:0};
    tbl[1] = '{a:255, b:255, n:200, hold:0, exp_sum:16'h8E70, exp_cnt:200, exp_sat:0};
    tbl[2] = '{a:1,   b:0,   n:300, hold:1, exp_sum:16'h012C, exp_cnt:255, exp_sat:1};
    tbl[3] = '{a:7,   b:9,   n:1,   hold:5, exp_sum:16,       exp_cnt:1,   exp_sat:0};
    tbl[4] = '{a:1,   b:1,   n:1,   hold:0, exp_sum:2,        exp_cnt:1,   exp_sat:0};

    rst_n = 1'b0; clr = 1'b0;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_last = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_sum", bus.out_sum, 0);
    chk("rst_out_count", bus.out_count, 0);
    chk("rst_out_sat", bus.out_cnt_sat, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", bus.in_ready, 1);

    foreach (tbl[j]) begin
      fill(tbl[j].a, tbl[j].b, tbl[j].n);
      run_job($sformatf("tbl%0d", j), 1'b0, tbl[j].hold,
              tbl[j].exp_sum, tbl[j].exp_cnt, tbl[j].exp_sat);
    end

    // four distinct back-to-back beats
    qa = '{10, 30, 50, 70}; qb = '{20, 40, 60, 80};
    run_job("four", 1'b0, 0, 16'h0168, 4, 0);

    // abort after three beats; a beat presented with clr is discarded
    fill(100, 100, 3);
    send_beats(1'b0, 1'b0, st);
    chk("clr_pre_count", bus.out_count, 3);
    clr = 1'b1; bus.in_valid = 1'b1; bus.in_a = 8'd50; bus.in_b = 8'd50;
    @(negedge clk);
    clr = 1'b0; bus.in_valid = 1'b0;
    chk("clr_count", bus.out_count, 0);
    chk("clr_ready", bus.in_ready, 1);
    qa = '{1}; qb = '{2};
    run_job("after_clr", 1'b0, 0, 3, 1, 0);

    // clr in DONE with out_ready drops the pending result
    qa = '{9}; qb = '{9};
    send_beats(1'b0, 1'b1, st);
    @(negedge clk);
    chk("clr_done_valid_pre", bus.out_valid, 1);
    clr = 1'b1; bus.out_ready = 1'b1;
    @(negedge clk);
    clr = 1'b0; bus.out_ready = 1'b0;
    chk("clr_done_valid", bus.out_valid, 0);
    chk("clr_done_sum", bus.out_sum, 0);

    // asynchronous reset mid-ACCUM
    fill(100, 100, 3);
    send_beats(1'b0, 1'b0, st);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ready", bus.in_ready, 0);
    chk("arst_count", bus.out_count, 0);
    chk("arst_valid", bus.out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    qa = '{4}; qb = '{4};
    run_job("after_rst", 1'b0, 0, 8, 1, 0);

    // random jobs against an arithmetic reference
    for (int r = 0; r < 12; r++) begin
      n = $urandom_range(1, 24);
      qa.delete(); qb.delete(); ref_sum = 0;
      for (int i = 0; i < n; i++) begin
        qa.push_back($urandom_range(0, 255));
        qb.push_back($urandom_range(0, 255));
        ref_sum += qa[i] + qb[i];
      end
      run_job($sformatf("rnd%0d", r), 1'b1, $urandom_range(0, 3),
              ref_sum % 65536, (n > 255) ? 255 : n, (n > 255) ? 1 : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
